// File: rtl/sfb_pkg.sv
// Shared definitions for the store forward buffer: meta layout and size codes
// as used by the CPU load/store unit.
package sfb_pkg;

  localparam int unsigned MW_DEF   = 4;
  localparam int unsigned SIGN_BIT = MW_DEF - 1;
  localparam int unsigned SIZE_W   = MW_DEF - 1;

  localparam logic [SIZE_W-1:0] SZ_BYTE = SIZE_W'(0);
  localparam logic [SIZE_W-1:0] SZ_HALF = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SZ_WORD = SIZE_W'(2);

  // Meta is {sign, size/offset}; sign occupies the MSB.
  typedef struct packed {
    logic              sign;
    logic [SIZE_W-1:0] size;
  } meta_t;

  function automatic logic [MW_DEF-1:0] make_meta(input logic sign,
                                                  input logic [SIZE_W-1:0] size);
    meta_t m;
    m.sign = sign;
    m.size = size;
    return MW_DEF'(m);
  endfunction

endpackage

// File: rtl/sfb_newest_match.sv
// Priority encoder selecting the newest matching valid entry, with age
// measured from the head pointer towards tail-1.
module sfb_newest_match #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_vec,
  input  logic [DEPTH-1:0] valid_vec,
  input  logic [PW-1:0]    head,
  output logic             hit,
  output logic [DEPTH-1:0] onehot
);

  logic [PW-1:0] pos;
  logic [PW-1:0] idx;

  // Walk oldest to newest; the last match seen is the newest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      pos = head + PW'(a);
      if (match_vec[pos] && valid_vec[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
    onehot = hit ? (DEPTH'(1) << idx) : '0;
  end

endmodule

// File: rtl/store_forward_buffer.sv
// Circular store buffer draining oldest-first to memory, with registered
// newest-match store-to-load forwarding including same-cycle write bypass.
module store_forward_buffer
  import sfb_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned MW    = MW_DEF,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [MW-1:0] WR_META,
  input  logic [DW-1:0] WR_DATA,
  output logic          WR_READY,
  input  logic          LK_EN,
  input  logic [AW-1:0] LK_ADDR,
  input  logic [MW-1:0] LK_META,
  output logic          LK_VALID,
  output logic          LK_HIT,
  output logic [DW-1:0] LK_DATA,
  output logic          DR_VALID,
  output logic [AW-1:0] DR_ADDR,
  output logic [MW-1:0] DR_META,
  output logic [DW-1:0] DR_DATA,
  input  logic          DR_READY,
  output logic [CW-1:0] COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [MW-1:0]    meta_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic             wr_fire;
  logic             pop;
  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] sel_oh;
  logic             mem_hit;
  logic [DW-1:0]    mem_data;
  logic             byp_hit;
  logic             lk_hit_c;
  logic [DW-1:0]    lk_data_c;

  assign COUNT    = count_q;
  assign FULL     = (count_q == CW'(DEPTH));
  assign EMPTY    = (count_q == '0);
  assign WR_READY = !FULL;
  assign DR_VALID = !EMPTY;

  assign wr_fire = WR_EN && !FULL;
  assign pop     = DR_VALID && DR_READY;

  assign DR_ADDR = EMPTY ? '0 : addr_q[head_q];
  assign DR_META = EMPTY ? '0 : meta_q[head_q];
  assign DR_DATA = EMPTY ? '0 : data_q[head_q];

  // Exact {addr, meta} compare against every slot; validity is applied downstream.
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_vec[i] = (addr_q[i] == LK_ADDR) && (meta_q[i] == LK_META);
    end
  end

  sfb_newest_match #(
    .DEPTH (DEPTH)
  ) u_newest (
    .match_vec (match_vec),
    .valid_vec (valid_q),
    .head      (head_q),
    .hit       (mem_hit),
    .onehot    (sel_oh)
  );

  always_comb begin
    mem_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        mem_data = mem_data | data_q[i];
      end
    end
  end

  // An accepted write in the lookup cycle is newer than anything stored.
  assign byp_hit   = wr_fire && (WR_ADDR == LK_ADDR) && (WR_META == LK_META);
  assign lk_hit_c  = byp_hit || mem_hit;
  assign lk_data_c = byp_hit ? WR_DATA : mem_data;

  always_ff @(posedge CLK) begin
    if (wr_fire && !RST) begin
      addr_q[tail_q] <= WR_ADDR;
      meta_q[tail_q] <= WR_META;
      data_q[tail_q] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      LK_VALID <= 1'b0;
      LK_HIT   <= 1'b0;
      LK_DATA  <= '0;
    end else begin
      if (wr_fire) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      // Head and tail only coincide when empty or full, so these never collide.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({wr_fire, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      LK_VALID <= LK_EN;
      LK_HIT   <= LK_EN && lk_hit_c;
      LK_DATA  <= (LK_EN && lk_hit_c) ? lk_data_c : '0;
    end
  end

endmodule

// File: tb/tb_store_forward_buffer.sv
// Bench for store_forward_buffer: table-driven cycles checked against a
// queue model of the buffer and a lookup scoreboard, plus corner sequences.
module tb_store_forward_buffer;
  import sfb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          CLK;
  logic          RST;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [MW-1:0] WR_META;
  logic [DW-1:0] WR_DATA;
  logic          WR_READY;
  logic          LK_EN;
  logic [AW-1:0] LK_ADDR;
  logic [MW-1:0] LK_META;
  logic          LK_VALID;
  logic          LK_HIT;
  logic [DW-1:0] LK_DATA;
  logic          DR_VALID;
  logic [AW-1:0] DR_ADDR;
  logic [MW-1:0] DR_META;
  logic [DW-1:0] DR_DATA;
  logic          DR_READY;
  logic [CW-1:0] COUNT;
  logic          FULL;
  logic          EMPTY;

  store_forward_buffer #(.AW(AW), .DW(DW), .MW(MW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_META(WR_META), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY),
    .LK_EN(LK_EN), .LK_ADDR(LK_ADDR), .LK_META(LK_META),
    .LK_VALID(LK_VALID), .LK_HIT(LK_HIT), .LK_DATA(LK_DATA),
    .DR_VALID(DR_VALID), .DR_ADDR(DR_ADDR), .DR_META(DR_META), .DR_DATA(DR_DATA),
    .DR_READY(DR_READY),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_meta;
    logic [DW-1:0] wr_data;
    logic          dr_ready;
    logic          lk_en;
    logic [AW-1:0] lk_addr;
    logic [MW-1:0] lk_meta;
    logic          chk;
    logic [CW-1:0] exp_count;
    logic [AW-1:0] exp_dr_addr;
    logic          exp_lkv;
    logic          exp_hit;
    logic [DW-1:0] exp_lk_data;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] meta;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          v;
    logic          hit;
    logic [DW-1:0] data;
  } lk_t;

  ent_t model[$];
  lk_t  lk_q[$];
  int   tests = 0;
  int   fails = 0;
  logic [MW-1:0] m_w;
  logic [MW-1:0] m_b;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int unsigned we, input int unsigned wa,
                              input logic [MW-1:0] wm, input int unsigned wd,
                              input int unsigned dr, input int unsigned le,
                              input int unsigned la, input logic [MW-1:0] lm);
    vec_t v;
    v.rst = 1'b0;
    v.wr_en = (we != 0);
    v.wr_addr = AW'(wa);
    v.wr_meta = wm;
    v.wr_data = DW'(wd);
    v.dr_ready = (dr != 0);
    v.lk_en = (le != 0);
    v.lk_addr = AW'(la);
    v.lk_meta = lm;
    v.chk = 1'b0;
    v.exp_count = '0;
    v.exp_dr_addr = '0;
    v.exp_lkv = 1'b0;
    v.exp_hit = 1'b0;
    v.exp_lk_data = '0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input int unsigned cnt, input int unsigned dra,
                              input int unsigned lkv, input int unsigned hit,
                              input int unsigned lkd);
    vec_t v;
    v = vi;
    v.chk = 1'b1;
    v.exp_count = CW'(cnt);
    v.exp_dr_addr = AW'(dra);
    v.exp_lkv = (lkv != 0);
    v.exp_hit = (hit != 0);
    v.exp_lk_data = DW'(lkd);
    return v;
  endfunction

  // Drive one cycle, check pre-edge outputs against the model, then advance the model.
  task automatic cycle(input vec_t v);
    lk_t  e;
    lk_t  r;
    ent_t w;
    logic acc;
    logic pop;
    int   n;
    RST = v.rst;
    WR_EN = v.wr_en;
    WR_ADDR = v.wr_addr;
    WR_META = v.wr_meta;
    WR_DATA = v.wr_data;
    DR_READY = v.dr_ready;
    LK_EN = v.lk_en;
    LK_ADDR = v.lk_addr;
    LK_META = v.lk_meta;
    #3;
    n = model.size();
    chk("count", 64'(COUNT), 64'(n));
    chk("full", 64'(FULL), 64'(n == int'(DEPTH)));
    chk("empty", 64'(EMPTY), 64'(n == 0));
    chk("wr_ready", 64'(WR_READY), 64'(n != int'(DEPTH)));
    chk("dr_valid", 64'(DR_VALID), 64'(n != 0));
    if (n > 0) begin
      chk("dr_addr", 64'(DR_ADDR), 64'(model[0].addr));
      chk("dr_meta", 64'(DR_META), 64'(model[0].meta));
      chk("dr_data", 64'(DR_DATA), 64'(model[0].data));
    end else begin
      chk("dr_addr_empty", 64'(DR_ADDR), 64'(0));
      chk("dr_data_empty", 64'(DR_DATA), 64'(0));
    end
    if (lk_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL lk_scoreboard: got empty queue expected an entry");
    end else begin
      e = lk_q.pop_front();
      chk("lk_valid", 64'(LK_VALID), 64'(e.v));
      chk("lk_hit", 64'(LK_HIT), 64'(e.hit));
      chk("lk_data", 64'(LK_DATA), 64'(e.data));
    end
    if (v.chk) begin
      chk("tbl_count", 64'(COUNT), 64'(v.exp_count));
      chk("tbl_dr_addr", 64'(DR_ADDR), 64'(v.exp_dr_addr));
      chk("tbl_lk_valid", 64'(LK_VALID), 64'(v.exp_lkv));
      chk("tbl_lk_hit", 64'(LK_HIT), 64'(v.exp_hit));
      chk("tbl_lk_data", 64'(LK_DATA), 64'(v.exp_lk_data));
    end
    r.v = 1'b0;
    r.hit = 1'b0;
    r.data = '0;
    if (v.rst) begin
      model.delete();
      lk_q.push_back(r);
    end else begin
      acc = v.wr_en && (n < int'(DEPTH));
      pop = v.dr_ready && (n > 0);
      if (v.lk_en) begin
        r.v = 1'b1;
        if (acc && v.wr_addr == v.lk_addr && v.wr_meta == v.lk_meta) begin
          r.hit = 1'b1;
          r.data = v.wr_data;
        end else begin
          for (int i = n - 1; i >= 0; i--) begin
            if (!r.hit && model[i].addr == v.lk_addr && model[i].meta == v.lk_meta) begin
              r.hit = 1'b1;
              r.data = model[i].data;
            end
          end
        end
      end
      lk_q.push_back(r);
      if (pop) void'(model.pop_front());
      if (acc) begin
        w.addr = v.wr_addr;
        w.meta = v.wr_meta;
        w.data = v.wr_data;
        model.push_back(w);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(mk(0, 0, m_w, 0, 1, 0, 0, m_w));
  endtask

  initial begin
    vec_t v;
    m_w = make_meta(1'b0, SZ_WORD);
    m_b = make_meta(1'b0, SZ_BYTE);
    RST = 1'b1;
    WR_EN = 1'b0; WR_ADDR = '0; WR_META = '0; WR_DATA = '0;
    LK_EN = 1'b0; LK_ADDR = '0; LK_META = '0; DR_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    lk_q.push_back('{v: 1'b0, hit: 1'b0, data: '0});

    // In-order drain, then newest-match and size-mismatch lookups.
    tbl[0]  = ex(mk(1, 'h100, m_w, 'hAAAA0001, 0, 0, 0, m_w), 0, 0, 0, 0, 0);
    tbl[1]  = ex(mk(1, 'h104, m_w, 'hAAAA0002, 0, 0, 0, m_w), 1, 'h100, 0, 0, 0);
    tbl[2]  = ex(mk(1, 'h108, m_w, 'hAAAA0003, 0, 0, 0, m_w), 2, 'h100, 0, 0, 0);
    tbl[3]  = ex(mk(0, 0, m_w, 0, 1, 0, 0, m_w), 3, 'h100, 0, 0, 0);
    tbl[4]  = ex(mk(0, 0, m_w, 0, 1, 0, 0, m_w), 2, 'h104, 0, 0, 0);
    tbl[5]  = ex(mk(0, 0, m_w, 0, 1, 0, 0, m_w), 1, 'h108, 0, 0, 0);
    tbl[6]  = ex(mk(0, 0, m_w, 0, 0, 0, 0, m_w), 0, 0, 0, 0, 0);
    tbl[7]  = ex(mk(1, 'h200, m_w, 'h11, 0, 0, 0, m_w), 0, 0, 0, 0, 0);
    tbl[8]  = ex(mk(1, 'h200, m_w, 'h22, 0, 0, 0, m_w), 1, 'h200, 0, 0, 0);
    tbl[9]  = ex(mk(0, 0, m_w, 0, 0, 1, 'h200, m_w), 2, 'h200, 0, 0, 0);
    tbl[10] = ex(mk(0, 0, m_w, 0, 0, 1, 'h200, m_b), 2, 'h200, 1, 1, 'h22);
    tbl[11] = ex(mk(0, 0, m_w, 0, 1, 0, 0, m_w), 2, 'h200, 1, 0, 0);
    tbl[12] = ex(mk(0, 0, m_w, 0, 1, 0, 0, m_w), 1, 'h200, 0, 0, 0);
    tbl[13] = ex(mk(0, 0, m_w, 0, 0, 0, 0, m_w), 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(tbl[i]);

    // Fill to full; a write while full is dropped even with a same-cycle pop.
    for (int i = 0; i < 8; i++) cycle(mk(1, 'h400 + 4 * i, m_w, 'hB000 + i, 0, 0, 0, m_w));
    chk("fill_full", 64'(FULL), 64'(1));
    chk("fill_wr_ready", 64'(WR_READY), 64'(0));
    cycle(mk(1, 'h4F0, m_w, 'hDEAD, 1, 0, 0, m_w));
    chk("drop_count", 64'(COUNT), 64'(7));
    drain(8);
    chk("drain_empty", 64'(EMPTY), 64'(1));

    // Interleaved writes and pops crossing the pointer wrap, with lookups.
    for (int i = 0; i < 12; i++)
      cycle(mk(1, 'h500 + 4 * (i % 3), m_w, 'hC00 + i, i % 2, 1, 'h500 + 4 * ((i + 1) % 3), m_w));
    cycle(mk(0, 0, m_w, 0, 0, 1, 'h500, m_w));
    chk("wrap_hit", 64'(LK_HIT), 64'(1));
    chk("wrap_newest", 64'(LK_DATA), 64'('hC09));
    drain(7);

    // Same-cycle write bypass beats an older stored match; head lookup during pop.
    cycle(mk(1, 'h310, m_w, 'h66, 0, 0, 0, m_w));
    cycle(mk(1, 'h300, m_w, 'h44, 0, 0, 0, m_w));
    cycle(mk(1, 'h300, m_w, 'h55, 0, 1, 'h300, m_w));
    chk("bypass_hit", 64'(LK_HIT), 64'(1));
    chk("bypass_data", 64'(LK_DATA), 64'('h55));
    cycle(mk(0, 0, m_w, 0, 1, 1, 'h310, m_w));
    chk("head_pop_hit", 64'(LK_HIT), 64'(1));
    chk("head_pop_data", 64'(LK_DATA), 64'('h66));
    drain(3);

    // Reset overrides concurrent write, pop and lookup; old contents are gone.
    for (int i = 0; i < 5; i++) cycle(mk(1, 'h600 + 4 * i, m_w, 'hE00 + i, 0, 0, 0, m_w));
    chk("pre_rst_count", 64'(COUNT), 64'(5));
    v = mk(1, 'h700, m_w, 'h77, 1, 1, 'h600, m_w);
    v.rst = 1'b1;
    cycle(v);
    chk("rst_count", 64'(COUNT), 64'(0));
    chk("rst_empty", 64'(EMPTY), 64'(1));
    chk("rst_lk_valid", 64'(LK_VALID), 64'(0));
    cycle(mk(0, 0, m_w, 0, 0, 1, 'h600, m_w));
    chk("old_lk_valid", 64'(LK_VALID), 64'(1));
    chk("old_miss", 64'(LK_HIT), 64'(0));
    cycle(mk(0, 0, m_w, 0, 0, 0, 0, m_w));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_forward_buffer.md
Name: store_forward_buffer

Overview:
- Parametrised successor of the shift-register store lookup.
- Circular store buffer between the CPU store path and data memory.
- Accepts stores tagged {addr, meta}, where meta = {sign, size/offset}, and drains them oldest-first to memory over a valid/ready handshake.
- Forwards data to loads on an exact {addr, meta} match; the newest matching entry wins. Lookup is registered with 1-cycle latency.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MW, 4, meta width (bit MW-1 = sign, low bits = size/offset code)
- DEPTH, 8, number of entries; power of 2, >= 2

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- WR_EN  in  1  store request
- WR_ADDR  in  AW  store address
- WR_META  in  MW  store meta
- WR_DATA  in  DW  store data
- WR_READY  out  1  buffer can accept; equals !FULL
- LK_EN  in  1  load lookup request
- LK_ADDR  in  AW  load address
- LK_META  in  MW  load meta
- LK_VALID  out  1  lookup result valid (1 cycle after LK_EN)
- LK_HIT  out  1  match found
- LK_DATA  out  DW  forwarded data; 0 on miss
- DR_VALID  out  1  head entry present; equals !EMPTY
- DR_ADDR  out  AW  head entry address
- DR_META  out  MW  head entry meta
- DR_DATA  out  DW  head entry data
- DR_READY  in  1  memory accepts head
- COUNT  out  $clog2(DEPTH)+1  occupied entries
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0

Behaviour:
- Reset (synchronous, RST high at posedge): head/tail pointers = 0, COUNT = 0, all entry valid bits = 0, LK_VALID = 0, LK_HIT = 0, LK_DATA = 0. FULL = 0, EMPTY = 1, DR_VALID = 0, WR_READY = 1. Stored entries are discarded. RST overrides all same-cycle WR/LK/DR activity.
- Write: accepted iff WR_EN && !FULL. The entry is stored at the tail; tail advances mod DEPTH; valid is set. WR_EN while FULL is ignored (no state change), even if a drain occurs in the same cycle.
- Drain: DR_* outputs are driven combinationally from the head entry. A pop occurs iff DR_VALID && DR_READY: head advances mod DEPTH and valid is cleared. DR_ADDR/META/DATA are don't-care when EMPTY; drive 0.
- Simultaneous accepted write and pop: COUNT unchanged; both pointers advance.
- COUNT update: +1 for write only, -1 for pop only, 0 for both or neither. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Lookup: sampled at the posedge where LK_EN = 1. Results appear on LK_VALID/LK_HIT/LK_DATA for exactly the following cycle. LK_VALID = 0 in cycles with no sampled request. On LK_VALID = 0, LK_HIT = 0 and LK_DATA = 0.
- Match rule: entry valid && {addr, meta} == {LK_ADDR, LK_META}. Partial overlap (e.g. a byte load hitting a word store) is a miss.
- Match set: all entries valid before the edge, including the head being popped that cycle, plus the same-cycle accepted write (bypass).
- Priority: same-cycle write > newest stored entry > older entries. Age is measured from head to tail-1.
- Lookup is independent of the write and drain paths; all three may fire in one cycle.
- No flow control on lookup; back-to-back LK_EN gives back-to-back results.

Decomposition:
- Shared package sfb_pkg:
  - meta field positions: SIGN_BIT = MW-1
  - size codes: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
  - the meta concatenation order used by the CPU load/store unit
- One sub-module, sfb_newest_match:
  - inputs: match vector, valid vector, head pointer
  - outputs: hit flag and one-hot/index of the newest match (rotate-relative-to-head priority encoder)
  - parametrised by DEPTH; purely combinational

Test Plan:
- Reset, then 3 writes (0x100/W/0xAAAA0001, 0x104/W/0xAAAA0002, 0x108/W/0xAAAA0003) with DR_READY = 0 -> COUNT = 3, DR_ADDR = 0x100; then DR_READY = 1 for 3 cycles -> pops in order 0x100, 0x104, 0x108; EMPTY = 1.
- Write 0x200/W/0x11 then 0x200/W/0x22; lookup 0x200/W -> next cycle LK_VALID = 1, LK_HIT = 1, LK_DATA = 0x22. Lookup 0x200/B -> LK_HIT = 0, LK_DATA = 0.
- Fill DEPTH = 8 entries -> FULL = 1, WR_READY = 0; a 9th write with DR_READY = 1 is dropped and the pop occurs -> COUNT = 7; the dropped address is never drained.
- Wrap-around: 12 writes interleaved with pops across the pointer wrap -> drain order matches write order; newest-match lookup is still correct across the wrap.
- Same-cycle write 0x300/W/0x55 with lookup 0x300/W, where an older 0x300/W/0x44 is stored -> LK_DATA = 0x55. Lookup on the head during its pop cycle -> hit with head data.
- RST asserted with COUNT = 5 and LK_EN = 1 -> next cycle COUNT = 0, EMPTY = 1, LK_VALID = 0; a later lookup of an old address misses.
